// File: rtl/ex_muldiv.sv
// Execute stage: combinational RV32I ALU and RV32M multiplies, plus a
// multi-cycle restoring divider that stalls the upstream pipeline while it runs.
module ex_muldiv #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  localparam logic [7:0] OP_ADD    = 8'h01;
  localparam logic [7:0] OP_SUB    = 8'h02;
  localparam logic [7:0] OP_SLL    = 8'h03;
  localparam logic [7:0] OP_SLT    = 8'h04;
  localparam logic [7:0] OP_SLTU   = 8'h05;
  localparam logic [7:0] OP_XOR    = 8'h06;
  localparam logic [7:0] OP_SRL    = 8'h07;
  localparam logic [7:0] OP_SRA    = 8'h08;
  localparam logic [7:0] OP_OR     = 8'h09;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_MUL    = 8'h10;
  localparam logic [7:0] OP_MULH   = 8'h11;
  localparam logic [7:0] OP_MULHSU = 8'h12;
  localparam logic [7:0] OP_MULHU  = 8'h13;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   dvs;
  logic [XLEN-1:0]   a_lat;
  logic              is_rem;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic              div_ovf;

  logic              is_div;
  logic              div_signed;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   alu_res;
  logic [4:0]        shamt;
  logic [2*XLEN-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [2*XLEN-1:0] p_ss, p_su, p_uu;

  // Div-class ops are 0x14..0x17: bit1 selects remainder, bit0 selects unsigned.
  assign is_div     = (aluop_i[7:2] == 6'b000101);
  assign div_signed = ~aluop_i[0];
  assign a_neg      = div_signed & reg1_i[XLEN-1];
  assign b_neg      = div_signed & reg2_i[XLEN-1];
  assign a_mag      = a_neg ? -reg1_i : reg1_i;
  assign b_mag      = b_neg ? -reg2_i : reg2_i;

  assign shamt = reg2_i[4:0];
  assign a_sx  = {{XLEN{reg1_i[XLEN-1]}}, reg1_i};
  assign b_sx  = {{XLEN{reg2_i[XLEN-1]}}, reg2_i};
  assign a_zx  = {{XLEN{1'b0}}, reg1_i};
  assign b_zx  = {{XLEN{1'b0}}, reg2_i};
  assign p_ss  = a_sx * b_sx;
  assign p_su  = a_sx * b_zx;
  assign p_uu  = a_zx * b_zx;

  // Combinational ALU and single-cycle multiplies.
  always_comb begin
    alu_res = '0;
    case (aluop_i)
      OP_ADD:    alu_res = reg1_i + reg2_i;
      OP_SUB:    alu_res = reg1_i - reg2_i;
      OP_SLL:    alu_res = reg1_i << shamt;
      OP_SLT:    alu_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU:   alu_res = {31'b0, reg1_i < reg2_i};
      OP_XOR:    alu_res = reg1_i ^ reg2_i;
      OP_SRL:    alu_res = reg1_i >> shamt;
      OP_SRA:    alu_res = XLEN'($signed(reg1_i) >>> shamt);
      OP_OR:     alu_res = reg1_i | reg2_i;
      OP_AND:    alu_res = reg1_i & reg2_i;
      OP_MUL:    alu_res = p_uu[XLEN-1:0];
      OP_MULH:   alu_res = p_ss[2*XLEN-1:XLEN];
      OP_MULHSU: alu_res = p_su[2*XLEN-1:XLEN];
      OP_MULHU:  alu_res = p_uu[2*XLEN-1:XLEN];
      default:   alu_res = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit and try to subtract.
  assign trial = {rem, quo[XLEN-1]} - {1'b0, dvs};

  // Divider FSM and datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      a_lat    <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_div) begin
            a_lat    <= reg1_i;
            is_rem   <= aluop_i[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            if (reg2_i == '0) begin
              div_zero <= 1'b1;
              state    <= S_DONE;
            end else if (div_signed && reg1_i == 32'h8000_0000 && reg2_i == 32'hFFFF_FFFF) begin
              div_ovf <= 1'b1;
              state   <= S_DONE;
            end else begin
              quo   <= a_mag;
              dvs   <= b_mag;
              rem   <= '0;
              cnt   <= '0;
              state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (!trial[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= {rem[XLEN-2:0], quo[XLEN-1]};
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sign fix-up and special-case selection, valid in DONE.
  always_comb begin
    div_res = '0;
    if (div_zero)     div_res = is_rem ? a_lat : '1;
    else if (div_ovf) div_res = is_rem ? '0 : 32'h8000_0000;
    else if (is_rem)  div_res = neg_r ? -rem : rem;
    else              div_res = neg_q ? -quo : quo;
  end

  assign stallreq = rst && ((state == S_IDLE && is_div) || state == S_BUSY);
  assign wd_o     = rst ? wd_i : 5'd0;
  assign wreg_o   = rst && wreg_i;

  always_comb begin
    wdata_o = '0;
    if (rst && alusel_i != 3'b000) begin
      if (state == S_DONE) wdata_o = div_res;
      else if (!is_div)    wdata_o = alu_res;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: randomized ALU/mul/div traffic against an
// arithmetic reference model, plus stall timing, special cases and reset.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq;

  int total  = 0;
  int passed = 0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  // Reference result straight from the RV32IM arithmetic definitions.
  function automatic logic [31:0] model(input logic [7:0] op, input logic [2:0] sel,
                                        input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint pa, pb, p;
    longint unsigned ua, ub, up;
    sa = int'(a);
    sb = int'(b);
    if (sel == 3'b000) return 32'h0;
    case (op)
      8'h01: return a + b;
      8'h02: return a - b;
      8'h03: return a << b[4:0];
      8'h04: return (sa < sb) ? 32'd1 : 32'd0;
      8'h05: return (a < b) ? 32'd1 : 32'd0;
      8'h06: return a ^ b;
      8'h07: return a >> b[4:0];
      8'h08: return 32'(sa >>> b[4:0]);
      8'h09: return a | b;
      8'h0A: return a & b;
      8'h10: begin ua = a; ub = b; up = ua * ub; return up[31:0]; end
      8'h11: begin pa = sa; pb = sb; p = pa * pb; return p[63:32]; end
      8'h12: begin pa = sa; pb = longint'({32'h0, b}); p = pa * pb; return p[63:32]; end
      8'h13: begin ua = a; ub = b; up = ua * ub; return up[63:32]; end
      8'h14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      8'h15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      8'h16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      8'h17: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int model_stalls(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic go_nop();
    @(posedge clk); #1;
    aluop = 8'h00; alusel = 3'b000; reg1 = 32'h0; reg2 = 32'h0; wreg = 1'b0; wd = 5'd0;
  endtask

  // Drive one divide and observe it until stallreq drops (bounded).
  task automatic div_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output int stalls, output logic [31:0] res,
                         output bit timeout);
    @(posedge clk); #1;
    aluop = op; alusel = 3'b100; reg1 = a; reg2 = b; wreg = 1'b1; wd = 5'd9;
    stalls = 0; timeout = 1'b1; res = 32'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stallreq) begin
        stalls++;
        if (scramble && stalls > 1) begin reg1 = $urandom; reg2 = $urandom; end
      end else begin
        res = wdata_o; timeout = 1'b0; break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    aluop = 8'h14; alusel = 3'b001; reg1 = 32'd5; reg2 = 32'd1; wd = 5'd7; wreg = 1'b1;
    #12;
    total++; if (stallreq !== 1'b0) $display("FAIL reset_stallreq got=%b exp=0", stallreq); else passed++;
    total++; if (wreg_o !== 1'b0) $display("FAIL reset_wreg got=%b exp=0", wreg_o); else passed++;
    total++; if (wd_o !== 5'd0) $display("FAIL reset_wd got=%0d exp=0", wd_o); else passed++;
    total++; if (wdata_o !== 32'h0) $display("FAIL reset_wdata got=%h exp=0", wdata_o); else passed++;
    aluop = 8'h00; alusel = 3'b000; wreg = 1'b0; wd = 5'd0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++; if (stallreq !== 1'b0) $display("FAIL post_reset_stallreq got=%b exp=0", stallreq); else passed++;
  endtask

  task automatic test_alu_directed();
    logic [7:0]  ops [10] = '{8'h01, 8'h08, 8'h05, 8'h04, 8'h11, 8'h12, 8'h13, 8'h10, 8'h01, 8'h03};
    logic [31:0] as  [10] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd1, 32'd1, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd1, 32'd1};
    logic [31:0] bs  [10] = '{32'd1, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd33};
    logic [31:0] exp [10] = '{32'h8000_0000, 32'hF800_0000, 32'd1, 32'd0, 32'h4000_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'd2, 32'd2};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      aluop = ops[i]; alusel = 3'b001; reg1 = as[i]; reg2 = bs[i]; wd = 5'(i + 1); wreg = 1'b1;
      @(negedge clk);
      total++; if (wdata_o !== exp[i]) $display("FAIL alu_dir[%0d] op=%h got=%h exp=%h", i, ops[i], wdata_o, exp[i]); else passed++;
      total++; if (stallreq !== 1'b0) $display("FAIL alu_dir_stall[%0d] got=%b exp=0", i, stallreq); else passed++;
    end
    // NOP result class overrides a live ALU op.
    @(posedge clk); #1;
    aluop = 8'h01; alusel = 3'b000; reg1 = 32'd3; reg2 = 32'd4;
    @(negedge clk);
    total++; if (wdata_o !== 32'h0) $display("FAIL alusel_nop got=%h exp=0", wdata_o); else passed++;
    go_nop();
  endtask

  task automatic test_alu_random();
    logic [7:0] ops [19] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                             8'h0A, 8'h10, 8'h11, 8'h12, 8'h13, 8'h0B, 8'h3C, 8'hFF, 8'h18};
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, b, exp;
    logic [4:0]  d;
    logic        w;
    for (int i = 0; i < 60; i++) begin
      op  = ops[$urandom_range(0, 18)];
      sel = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      a   = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1, 31'h0};
      d = 5'($urandom); w = 1'($urandom);
      exp = model(op, sel, a, b);
      @(posedge clk); #1;
      aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
      @(negedge clk);
      total++; if (wdata_o !== exp) $display("FAIL alu_rand op=%h a=%h b=%h got=%h exp=%h", op, a, b, wdata_o, exp); else passed++;
      total++; if (stallreq !== 1'b0) $display("FAIL alu_rand_stall op=%h got=%b exp=0", op, stallreq); else passed++;
      total++; if (wd_o !== d || wreg_o !== w) $display("FAIL passthru got=%0d/%b exp=%0d/%b", wd_o, wreg_o, d, w); else passed++;
    end
    go_nop();
  endtask

  task automatic test_div_directed();
    logic [7:0]  ops [8] = '{8'h14, 8'h16, 8'h15, 8'h17, 8'h15, 8'h16, 8'h14, 8'h16};
    logic [31:0] as  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                             32'h8000_0000, 32'd0};
    int          est [8] = '{33, 33, 33, 33, 1, 1, 1, 1};
    int          stalls;
    logic [31:0] res;
    bit          to;
    for (int i = 0; i < 8; i++) begin
      div_txn(ops[i], as[i], bs[i], 1'b1, stalls, res, to);
      total++; if (to) $display("FAIL div_dir_timeout[%0d] got=timeout exp=done", i); else passed++;
      total++; if (stalls != est[i]) $display("FAIL div_dir_stalls[%0d] got=%0d exp=%0d", i, stalls, est[i]); else passed++;
      total++; if (res !== exp[i]) $display("FAIL div_dir_result[%0d] op=%h got=%h exp=%h", i, ops[i], res, exp[i]); else passed++;
      go_nop();
    end
  endtask

  task automatic test_div_random();
    logic [7:0]  op;
    logic [31:0] a, b, exp;
    int          stalls, est;
    logic [31:0] res;
    bit          to;
    for (int i = 0; i < 12; i++) begin
      op = 8'(8'h14 + $urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(1, 20));
        1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        2:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      exp = model(op, 3'b100, a, b);
      est = model_stalls(op, a, b);
      div_txn(op, a, b, 1'b1, stalls, res, to);
      total++; if (to) $display("FAIL div_rand_timeout op=%h got=timeout exp=done", op); else passed++;
      total++; if (stalls != est) $display("FAIL div_rand_stalls op=%h got=%0d exp=%0d", op, stalls, est); else passed++;
      total++; if (res !== exp) $display("FAIL div_rand_result op=%h a=%h b=%h got=%h exp=%h", op, a, b, res, exp); else passed++;
      go_nop();
    end
  endtask

  task automatic test_back_to_back();
    int          s1, s2;
    logic [31:0] r1, r2;
    bit          t1, t2;
    div_txn(8'h15, 32'd100, 32'd7, 1'b0, s1, r1, t1);
    div_txn(8'h15, 32'd9, 32'd3, 1'b0, s2, r2, t2);
    go_nop();
    total++; if (t1 || t2) $display("FAIL b2b_timeout got=%b%b exp=00", t1, t2); else passed++;
    total++; if (s1 != 33 || s2 != 33) $display("FAIL b2b_stalls got=%0d,%0d exp=33,33", s1, s2); else passed++;
    total++; if (r1 !== 32'd14) $display("FAIL b2b_first got=%h exp=%h", r1, 32'd14); else passed++;
    total++; if (r2 !== 32'd3) $display("FAIL b2b_second got=%h exp=%h", r2, 32'd3); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (stallreq !== 1'b0) $display("FAIL b2b_idle_stall[%0d] got=%b exp=0", i, stallreq); else passed++;
    end
  endtask

  task automatic test_reset_mid_busy();
    int          seen;
    int          stalls;
    logic [31:0] res;
    bit          to;
    @(posedge clk); #1;
    aluop = 8'h15; alusel = 3'b100; reg1 = 32'd100; reg2 = 32'd7; wreg = 1'b1; wd = 5'd3;
    seen = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (stallreq) seen++;
    end
    total++; if (seen != 11) $display("FAIL rst_busy_prestall got=%0d exp=11", seen); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (stallreq !== 1'b0) $display("FAIL rst_busy_stall got=%b exp=0", stallreq); else passed++;
    total++; if (wdata_o !== 32'h0 || wreg_o !== 1'b0 || wd_o !== 5'd0)
      $display("FAIL rst_busy_outs got=%h/%b/%0d exp=0/0/0", wdata_o, wreg_o, wd_o); else passed++;
    aluop = 8'h00; alusel = 3'b000; wreg = 1'b0; wd = 5'd0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++; if (stallreq !== 1'b0) $display("FAIL rst_busy_idle got=%b exp=0", stallreq); else passed++;
    div_txn(8'h15, 32'd9, 32'd3, 1'b0, stalls, res, to);
    go_nop();
    total++; if (to) $display("FAIL rst_busy_timeout got=timeout exp=done"); else passed++;
    total++; if (stalls != 33) $display("FAIL rst_busy_redo_stalls got=%0d exp=33", stalls); else passed++;
    total++; if (res !== 32'd3) $display("FAIL rst_busy_redo_result got=%h exp=%h", res, 32'd3); else passed++;
  endtask

  initial begin
    rst = 1'b0; aluop = 8'h00; alusel = 3'b000; reg1 = 32'h0; reg2 = 32'h0; wd = 5'd0; wreg = 1'b0;
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_div_directed();
    test_div_random();
    test_back_to_back();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
